// File: rtl/axum_arb_pkg.sv
// Shared definitions for the host arbiter slice.
// - arb_state_e : arbiter FSM states (ARB = free arbitration, HOLD = locked on a stalled winner)
// - id_width()  : host-ID width, $clog2(n) but never less than one bit
package axum_arb_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axum_id_fifo.sv
// Small synchronous in-order FIFO used to remember which host owns each
// outstanding request. Reusable for any in-order response tracker.
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes contents)
//   push, push_data   write an entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   head              oldest entry, valid while !empty
//   full, empty       occupancy flags, derived from the registered count
module axum_id_fifo
    import axum_arb_pkg::*;
#(
    parameter int Depth = 2,
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FullCnt);
    assign empty   = (count == CntW'(0));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LastPtr) ? PtrW'(0) : wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? PtrW'(0) : rd_ptr + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axum_host_arb.sv
// Round-robin arbiter sharing one req/gnt/rvalid bus host slot between
// several upstream hosts. A stalled winner is locked until granted, and an
// in-order ID FIFO routes each response back to the host that issued it.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   host_*_i / host_*_o        per-host request side (packed per host)
//   dev_*_o / dev_*_i          single downstream host port
//   protocol_err_o             registered one-cycle pulse for a response
//                              arriving with nothing outstanding
module axum_host_arb
    import axum_arb_pkg::*;
#(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NrHosts-1:0]                    host_req_i,
    output logic [NrHosts-1:0]                    host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i,
    input  logic [NrHosts-1:0]                    host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]   host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i,
    output logic [NrHosts-1:0]                    host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o,
    output logic [NrHosts-1:0]                    host_err_o,
    output logic                                  dev_req_o,
    input  logic                                  dev_gnt_i,
    output logic [AddressWidth-1:0]               dev_addr_o,
    output logic                                  dev_we_o,
    output logic [DataWidth/8-1:0]                dev_be_o,
    output logic [DataWidth-1:0]                  dev_wdata_o,
    input  logic                                  dev_rvalid_i,
    input  logic [DataWidth-1:0]                  dev_rdata_i,
    input  logic                                  dev_err_i,
    output logic                                  protocol_err_o
);

    localparam int IdW = id_width(NrHosts);
    localparam logic [IdW-1:0] LastId = IdW'(NrHosts - 1);

    arb_state_e     state;
    logic [IdW-1:0] rr_ptr;
    logic [IdW-1:0] locked_id;
    logic [IdW-1:0] arb_winner;
    logic [IdW-1:0] winner;
    logic [IdW-1:0] rr_next;
    logic [IdW-1:0] fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           granted;
    logic           resp_pop;

    // Round-robin search starting at rr_ptr and wrapping past the last host.
    always_comb begin
        logic           found;
        int             idx;
        logic [IdW-1:0] cand;
        found      = 1'b0;
        idx        = 0;
        cand       = '0;
        arb_winner = rr_ptr;
        for (int i = 0; i < NrHosts; i++) begin
            idx  = (int'(rr_ptr) + i) % NrHosts;
            cand = IdW'(idx);
            if (!found && host_req_i[cand]) begin
                found      = 1'b1;
                arb_winner = cand;
            end else begin
                found = found;
            end
        end
    end

    // A stalled winner keeps the slot regardless of other requests.
    assign winner  = (state == HOLD) ? locked_id : arb_winner;
    assign rr_next = (winner == LastId) ? IdW'(0) : winner + IdW'(1);

    // Full is the registered flag, so a same-cycle pop cannot free a slot.
    assign dev_req_o   = ~rst_i & host_req_i[winner] & ~fifo_full;
    assign granted     = dev_req_o & dev_gnt_i;
    assign resp_pop    = ~rst_i & dev_rvalid_i & ~fifo_empty;
    assign dev_addr_o  = host_addr_i[winner];
    assign dev_we_o    = host_we_i[winner];
    assign dev_be_o    = host_be_i[winner];
    assign dev_wdata_o = host_wdata_i[winner];

    // One-hot grant to the winner and response valid to the FIFO head owner.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = '0;
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h]    = granted & (winner == IdW'(h));
            host_rvalid_o[h] = resp_pop & (fifo_head == IdW'(h));
            host_rdata_o[h]  = dev_rdata_i;
            host_err_o[h]    = dev_err_i;
        end
    end

    // Arbiter FSM, round-robin pointer and the spurious-response pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ARB;
            rr_ptr         <= '0;
            locked_id      <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            protocol_err_o <= dev_rvalid_i & fifo_empty;
            case (state)
                ARB: begin
                    if (dev_req_o && !dev_gnt_i) begin
                        state     <= HOLD;
                        locked_id <= arb_winner;
                    end else begin
                        state <= ARB;
                    end
                end
                HOLD: begin
                    if (granted) begin
                        state <= ARB;
                    end else begin
                        state <= HOLD;
                    end
                end
                default: state <= ARB;
            endcase
            if (granted) begin
                rr_ptr <= rr_next;
            end else begin
                rr_ptr <= rr_ptr;
            end
        end
    end

    axum_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (granted),
        .push_data (winner),
        .pop       (resp_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_axum_host_arb.sv
// Self-checking bench for axum_host_arb (2 hosts, 2 outstanding).
// A directed vector table covers the listed corner cases; a randomized phase
// is checked against a queue-based reference model of the arbitration rules.
module tb_axum_host_arb;

    localparam int N    = 2;
    localparam int MAXO = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        host_req;
    logic [N-1:0]        host_gnt;
    logic [N-1:0][31:0]  host_addr;
    logic [N-1:0]        host_we;
    logic [N-1:0][3:0]   host_be;
    logic [N-1:0][31:0]  host_wdata;
    logic [N-1:0]        host_rvalid;
    logic [N-1:0][31:0]  host_rdata;
    logic [N-1:0]        host_err;
    logic                dev_req;
    logic                dev_gnt;
    logic [31:0]         dev_addr;
    logic                dev_we;
    logic [3:0]          dev_be;
    logic [31:0]         dev_wdata;
    logic                dev_rvalid;
    logic [31:0]         dev_rdata;
    logic                dev_err;
    logic                protocol_err;

    always #5 clk = ~clk;

    axum_host_arb #(
        .NrHosts(N), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr),
        .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
        .protocol_err_o(protocol_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: issue-ordered owners, next-priority host,
    // host currently waiting on a stalled request (-1 if none).
    int   q[$];
    int   ptr     = 0;
    int   waiting = -1;
    logic perr_exp = 1'b0;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       gnt;
        logic       rv;
        logic       exp_req;
        logic [1:0] exp_gnt;
        logic [1:0] exp_rv;
        logic       exp_perr;
        int         exp_host;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] rq, input logic g, input logic v,
                       input logic er, input logic [1:0] eg, input logic [1:0] ev,
                       input logic ep, input int eh);
        vec_t t;
        t.rst = r; t.req = rq; t.gnt = g; t.rv = v;
        t.exp_req = er; t.exp_gnt = eg; t.exp_rv = ev; t.exp_perr = ep; t.exp_host = eh;
        tbl.push_back(t);
    endtask

    // Compare DUT against the model for the inputs currently applied, then
    // advance the model to the state after the coming clock edge.
    task automatic model_step(input bit do_check);
        int         cand;
        logic       e_req;
        logic [1:0] e_gnt;
        logic [1:0] e_rv;
        cand  = -1;
        e_gnt = '0;
        e_rv  = '0;
        if (waiting >= 0) begin
            cand = waiting;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cand < 0 && host_req[(ptr + i) % N]) cand = (ptr + i) % N;
            end
        end
        e_req = !rst && cand >= 0 && host_req[cand] && q.size() < MAXO;
        if (e_req && dev_gnt) e_gnt[cand] = 1'b1;
        if (!rst && dev_rvalid && q.size() > 0) e_rv[q[0]] = 1'b1;
        if (do_check) begin
            chk("m_dev_req", 64'(dev_req), 64'(e_req));
            chk("m_host_gnt", 64'(host_gnt), 64'(e_gnt));
            chk("m_host_rvalid", 64'(host_rvalid), 64'(e_rv));
            chk("m_protocol_err", 64'(protocol_err), 64'(perr_exp));
            chk("m_rdata0", 64'(host_rdata[0]), 64'(dev_rdata));
            chk("m_rdata1", 64'(host_rdata[1]), 64'(dev_rdata));
            if (e_req) begin
                chk("m_dev_addr", 64'(dev_addr), 64'(host_addr[cand]));
                chk("m_dev_wdata", 64'(dev_wdata), 64'(host_wdata[cand]));
                chk("m_dev_we_be", 64'({dev_we, dev_be}), 64'({host_we[cand], host_be[cand]}));
            end
            if (e_rv != 2'b00) chk("m_host_err", 64'(host_err[q[0]]), 64'(dev_err));
        end
        if (rst) begin
            q.delete();
            ptr      = 0;
            waiting  = -1;
            perr_exp = 1'b0;
        end else begin
            perr_exp = dev_rvalid && q.size() == 0;
            if (dev_rvalid && q.size() > 0) void'(q.pop_front());
            if (e_req && dev_gnt) begin
                q.push_back(cand);
                ptr     = (cand + 1) % N;
                waiting = -1;
            end else if (e_req) begin
                waiting = cand;
            end
        end
    endtask

    initial begin
        logic [31:0] exp_addr;
        rst        = 1'b1;
        host_req   = '0;
        host_addr[0] = 32'h0002_0000;
        host_addr[1] = 32'h0003_0000;
        host_we    = 2'b10;
        host_be    = {4'hC, 4'hF};
        host_wdata = {32'h1111_2222, 32'h3333_4444};
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_rdata  = 32'hDEAD_BEEF;
        dev_err    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_step(1'b0);

        //   rst req   gnt rv  e_req e_gnt e_rv  perr host
        add(1, 2'b11, 1, 1,  0, 2'b00, 2'b00, 0, -1); // reset forces outputs low
        add(0, 2'b01, 1, 0,  1, 2'b01, 2'b00, 0,  0); // single host read
        add(0, 2'b00, 1, 1,  0, 2'b00, 2'b01, 0, -1); // response to host0
        add(0, 2'b11, 1, 0,  1, 2'b10, 2'b00, 0,  1); // contention, ptr at 1
        add(0, 2'b11, 1, 1,  1, 2'b01, 2'b10, 0,  0); // wrap to 0, push+pop
        add(0, 2'b11, 1, 1,  1, 2'b10, 2'b01, 0,  1);
        add(0, 2'b11, 1, 1,  1, 2'b01, 2'b10, 0,  0);
        add(0, 2'b00, 0, 1,  0, 2'b00, 2'b01, 0, -1); // drain
        add(0, 2'b11, 0, 0,  1, 2'b00, 2'b00, 0,  1); // host1 stalls
        add(0, 2'b11, 0, 0,  1, 2'b00, 2'b00, 0,  1);
        add(0, 2'b11, 0, 0,  1, 2'b00, 2'b00, 0,  1);
        add(0, 2'b11, 1, 0,  1, 2'b10, 2'b00, 0,  1); // host1 granted first
        add(0, 2'b11, 1, 0,  1, 2'b01, 2'b00, 0,  0); // then host0, FIFO full
        add(0, 2'b11, 1, 0,  0, 2'b00, 2'b00, 0, -1); // blocked while full
        add(0, 2'b11, 1, 1,  0, 2'b00, 2'b10, 0, -1); // pop does not unblock
        add(0, 2'b11, 1, 1,  1, 2'b10, 2'b01, 0,  1); // in-order second response
        add(0, 2'b00, 0, 1,  0, 2'b00, 2'b10, 0, -1);
        add(0, 2'b01, 1, 0,  1, 2'b01, 2'b00, 0,  0); // two outstanding
        add(0, 2'b10, 1, 0,  1, 2'b10, 2'b00, 0,  1);
        add(1, 2'b00, 0, 0,  0, 2'b00, 2'b00, 0, -1); // reset flushes
        add(0, 2'b00, 0, 1,  0, 2'b00, 2'b00, 0, -1); // late response dropped
        add(0, 2'b00, 0, 0,  0, 2'b00, 2'b00, 1, -1); // error pulse
        add(0, 2'b00, 0, 0,  0, 2'b00, 2'b00, 0, -1); // single cycle only

        for (int i = 0; i < tbl.size(); i++) begin
            rst        = tbl[i].rst;
            host_req   = tbl[i].req;
            dev_gnt    = tbl[i].gnt;
            dev_rvalid = tbl[i].rv;
            #2;
            chk($sformatf("v%0d_dev_req", i), 64'(dev_req), 64'(tbl[i].exp_req));
            chk($sformatf("v%0d_host_gnt", i), 64'(host_gnt), 64'(tbl[i].exp_gnt));
            chk($sformatf("v%0d_host_rvalid", i), 64'(host_rvalid), 64'(tbl[i].exp_rv));
            chk($sformatf("v%0d_protocol_err", i), 64'(protocol_err), 64'(tbl[i].exp_perr));
            if (tbl[i].exp_host >= 0) begin
                exp_addr = (tbl[i].exp_host == 0) ? 32'h0002_0000 : 32'h0003_0000;
                chk($sformatf("v%0d_dev_addr", i), 64'(dev_addr), 64'(exp_addr));
            end
            if (tbl[i].exp_rv != 2'b00) begin
                chk($sformatf("v%0d_rdata", i), 64'(host_rdata[0]), 64'h0000_0000_DEAD_BEEF);
            end
            model_step(1'b1);
            @(posedge clk);
            #1;
        end

        // Randomized traffic; a waiting host keeps its request and address.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            host_req = 2'($urandom);
            for (int h = 0; h < N; h++) begin
                if (h != waiting) host_addr[h] = $urandom;
                host_wdata[h] = $urandom;
                host_be[h]    = 4'($urandom);
                host_we[h]    = 1'($urandom);
            end
            if (waiting >= 0) host_req[waiting] = 1'b1;
            dev_gnt    = ($urandom_range(0, 2) != 0);
            dev_rvalid = ($urandom_range(0, 2) == 0);
            dev_rdata  = $urandom;
            dev_err    = 1'($urandom);
            #2;
            model_step(1'b1);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
